branch_redirect_ctrl: RTL and testbench

- Sequences front-end redirection after dual-issue branch/JAL/JALR resolution.
- Consumes per-slot resolution results (ir0 = older, ir1 = younger): branch/JAL outcome, JALR target and CHERIoT CJALR check result.
- Selects the oldest redirect-causing event and kills the younger slot in the same cycle.
- Drives a valid/ready redirect request to fetch, or an exception request for CJALR violations, and stalls issue until the front end has re-steered.

---
 rtl/branch_redirect_ctrl_pkg.sv | 32 +++
 rtl/branch_redirect_ctrl.sv | 151 +++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the branch redirect controller.
package branch_redirect_ctrl_pkg;

    // Per-slot branch resolution flags; bit0 = ir0 (older), bit1 = ir1 (younger).
    typedef struct packed {
        logic [1:0] branch_taken;
        logic [1:0] mispredict_taken;
        logic [1:0] mispredict_not_taken;
    } branch_info_t;

    typedef enum logic [1:0] {
        RS_IDLE  = 2'd0,
        RS_REDIR = 2'd1,
        RS_EXC   = 2'd2,
        RS_DRAIN = 2'd3
    } redir_state_e;

    // Bit positions inside the {EX, SEAL, TAG} CJALR violation vector.
    localparam int CJALR_TAG_BIT  = 0;
    localparam int CJALR_SEAL_BIT = 1;
    localparam int CJALR_EX_BIT   = 2;

    function automatic logic cjalr_any(input logic [2:0] err);
        return err[CJALR_EX_BIT] | err[CJALR_SEAL_BIT] | err[CJALR_TAG_BIT];
    endfunction

    // JALR targets always have bit 0 cleared.
    function automatic logic [31:0] jalr_align(input logic [31:0] target);
        return {target[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer for dual-issue branch/JAL/JALR resolution.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RS_IDLE  | watching resolution results, no request outstanding
// RS_REDIR | redirect request held until fetch accepts it
// RS_EXC   | CJALR exception request held until commit/trap acks it
// RS_DRAIN | front end re-steering, issue held for DRAIN_CYCLES cycles
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter logic CHERIoTEn    = 1'b1,
    parameter int   DRAIN_CYCLES = 2,
    parameter int   CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        ir_valid_i,
    input  branch_info_t      branch_info_i,
    input  logic [1:0]        ir_is_jalr_i,
    input  logic [31:0]       ir0_btarget_i,
    input  logic [31:0]       ir1_btarget_i,
    input  logic [31:0]       ir0_npc_i,
    input  logic [31:0]       ir1_npc_i,
    input  logic [31:0]       ir0_jalr_target_i,
    input  logic [31:0]       ir1_jalr_target_i,
    input  logic [2:0]        ir0_cjalr_err_i,
    input  logic [2:0]        ir1_cjalr_err_i,
    output logic              flush_ir1_o,
    output logic              issue_stall_o,
    output logic              redir_valid_o,
    input  logic              redir_ready_i,
    output logic [31:0]       redir_pc_o,
    output logic              exc_valid_o,
    input  logic              exc_ack_i,
    output logic [2:0]        exc_cause_o,
    output logic              exc_slot_o,
    output logic [CNT_W-1:0]  mispred_cnt_o
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    redir_state_e state;
    logic [3:0]   drain_cnt;

    logic [1:0]   slot_ev;
    logic [1:0]   slot_err;
    logic [31:0]  slot0_pc;
    logic [31:0]  slot1_pc;
    logic         sel_slot;
    logic         sel_hit;
    logic         sel_err;
    logic [31:0]  sel_pc;
    logic [2:0]   sel_cause;

    // Predicted-taken information is not needed to decide a redirect.
    logic unused_branch_taken;
    assign unused_branch_taken = ^branch_info_i.branch_taken;

    // Per-slot event, CJALR error and redirect target.
    assign slot_ev[0] = ir_valid_i[0] & (branch_info_i.mispredict_taken[0] |
                                         branch_info_i.mispredict_not_taken[0] |
                                         ir_is_jalr_i[0]);
    assign slot_ev[1] = ir_valid_i[1] & (branch_info_i.mispredict_taken[1] |
                                         branch_info_i.mispredict_not_taken[1] |
                                         ir_is_jalr_i[1]);

    assign slot_err[0] = ir_valid_i[0] & ir_is_jalr_i[0] & cjalr_any(ir0_cjalr_err_i) & CHERIoTEn;
    assign slot_err[1] = ir_valid_i[1] & ir_is_jalr_i[1] & cjalr_any(ir1_cjalr_err_i) & CHERIoTEn;

    assign slot0_pc = branch_info_i.mispredict_taken[0]     ? ir0_btarget_i :
                      branch_info_i.mispredict_not_taken[0] ? ir0_npc_i     :
                                                              jalr_align(ir0_jalr_target_i);
    assign slot1_pc = branch_info_i.mispredict_taken[1]     ? ir1_btarget_i :
                      branch_info_i.mispredict_not_taken[1] ? ir1_npc_i     :
                                                              jalr_align(ir1_jalr_target_i);

    // The older slot wins; ir1 is only considered when ir0 has no event.
    assign sel_slot  = ~slot_ev[0];
    assign sel_hit   = |slot_ev;
    assign sel_err   = sel_slot ? slot_err[1]     : slot_err[0];
    assign sel_pc    = sel_slot ? slot1_pc        : slot0_pc;
    assign sel_cause = sel_slot ? ir1_cjalr_err_i : ir0_cjalr_err_i;

    assign flush_ir1_o = (state == RS_IDLE) & slot_ev[0] & ir_valid_i[1];

    // Redirect/exception sequencing with registered request outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= RS_IDLE;
            drain_cnt     <= '0;
            issue_stall_o <= 1'b0;
            redir_valid_o <= 1'b0;
            redir_pc_o    <= '0;
            exc_valid_o   <= 1'b0;
            exc_cause_o   <= '0;
            exc_slot_o    <= 1'b0;
            mispred_cnt_o <= '0;
        end else begin
            case (state)
                RS_IDLE: begin
                    if (sel_hit) begin
                        issue_stall_o <= 1'b1;
                        if (sel_err) begin
                            state       <= RS_EXC;
                            exc_valid_o <= 1'b1;
                            exc_cause_o <= sel_cause;
                            exc_slot_o  <= sel_slot;
                        end else begin
                            state         <= RS_REDIR;
                            redir_valid_o <= 1'b1;
                            redir_pc_o    <= sel_pc;
                        end
                    end
                end
                RS_REDIR: begin
                    if (redir_ready_i) begin
                        state         <= RS_DRAIN;
                        redir_valid_o <= 1'b0;
                        drain_cnt     <= DRAIN_LOAD;
                        if (mispred_cnt_o != '1) begin
                            mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
                        end
                    end
                end
                RS_EXC: begin
                    if (exc_ack_i) begin
                        state       <= RS_DRAIN;
                        exc_valid_o <= 1'b0;
                        drain_cnt   <= DRAIN_LOAD;
                    end
                end
                RS_DRAIN: begin
                    if (drain_cnt == 4'd0) begin
                        state         <= RS_IDLE;
                        issue_stall_o <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                default: begin
                    state         <= RS_IDLE;
                    issue_stall_o <= 1'b0;
                    redir_valid_o <= 1'b0;
                    exc_valid_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: vector table, directed
// corner sequences, then random stimulus against a behavioural model.
module tb_branch_redirect_ctrl;
    import branch_redirect_ctrl_pkg::*;

    localparam int DRAIN = 2;

    logic        clk;
    logic        rst;
    logic [1:0]  v, btk, mt, mnt, jr;
    logic [31:0] bt0, bt1, np0, np1, jt0, jt1;
    logic [2:0]  e0, e1;
    logic        ready, ack;
    branch_info_t bi;

    // Index 0: default DUT, 1: CHERIoTEn=0, 2: CNT_W=2.
    logic        flush [3];
    logic        stall [3];
    logic        rv    [3];
    logic        ev    [3];
    logic [31:0] pc    [3];
    logic [2:0]  cause [3];
    logic        slot  [3];
    logic [15:0] cnt   [3];
    logic [1:0]  cnt_c2;

    int n_chk = 0;
    int n_err = 0;

    assign bi = '{branch_taken: btk, mispredict_taken: mt, mispredict_not_taken: mnt};
    assign cnt[2] = {14'd0, cnt_c2};

    branch_redirect_ctrl u_main (
        .clk_i(clk), .rst_i(rst), .ir_valid_i(v), .branch_info_i(bi), .ir_is_jalr_i(jr),
        .ir0_btarget_i(bt0), .ir1_btarget_i(bt1), .ir0_npc_i(np0), .ir1_npc_i(np1),
        .ir0_jalr_target_i(jt0), .ir1_jalr_target_i(jt1),
        .ir0_cjalr_err_i(e0), .ir1_cjalr_err_i(e1),
        .flush_ir1_o(flush[0]), .issue_stall_o(stall[0]), .redir_valid_o(rv[0]),
        .redir_ready_i(ready), .redir_pc_o(pc[0]), .exc_valid_o(ev[0]), .exc_ack_i(ack),
        .exc_cause_o(cause[0]), .exc_slot_o(slot[0]), .mispred_cnt_o(cnt[0]));

    branch_redirect_ctrl #(.CHERIoTEn(1'b0)) u_nc (
        .clk_i(clk), .rst_i(rst), .ir_valid_i(v), .branch_info_i(bi), .ir_is_jalr_i(jr),
        .ir0_btarget_i(bt0), .ir1_btarget_i(bt1), .ir0_npc_i(np0), .ir1_npc_i(np1),
        .ir0_jalr_target_i(jt0), .ir1_jalr_target_i(jt1),
        .ir0_cjalr_err_i(e0), .ir1_cjalr_err_i(e1),
        .flush_ir1_o(flush[1]), .issue_stall_o(stall[1]), .redir_valid_o(rv[1]),
        .redir_ready_i(ready), .redir_pc_o(pc[1]), .exc_valid_o(ev[1]), .exc_ack_i(ack),
        .exc_cause_o(cause[1]), .exc_slot_o(slot[1]), .mispred_cnt_o(cnt[1]));

    branch_redirect_ctrl #(.CNT_W(2)) u_c2 (
        .clk_i(clk), .rst_i(rst), .ir_valid_i(v), .branch_info_i(bi), .ir_is_jalr_i(jr),
        .ir0_btarget_i(bt0), .ir1_btarget_i(bt1), .ir0_npc_i(np0), .ir1_npc_i(np1),
        .ir0_jalr_target_i(jt0), .ir1_jalr_target_i(jt1),
        .ir0_cjalr_err_i(e0), .ir1_cjalr_err_i(e1),
        .flush_ir1_o(flush[2]), .issue_stall_o(stall[2]), .redir_valid_o(rv[2]),
        .redir_ready_i(ready), .redir_pc_o(pc[2]), .exc_valid_o(ev[2]), .exc_ack_i(ack),
        .exc_cause_o(cause[2]), .exc_slot_o(slot[2]), .mispred_cnt_o(cnt_c2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_in();
        v = 2'b00; btk = 2'b00; mt = 2'b00; mnt = 2'b00; jr = 2'b00;
        e0 = 3'd0; e1 = 3'd0;
    endtask

    task automatic set_targets();
        bt0 = 32'h100; bt1 = 32'h200; np0 = 32'h104; np1 = 32'h204;
        jt0 = 32'h301; jt1 = 32'h3001;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  v, mt, mnt, jr;
        logic [2:0]  e0, e1;
        logic        fl, rv, ev;
        logic [31:0] pc;
        logic [2:0]  cause;
        logic        slot;
        logic        nrv;
        logic [31:0] npc;
    } vec_t;

    vec_t vt [13];
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;

    // ---------------- random-phase reference model ----------------
    bit          m_rv    [3];
    bit          m_ev    [3];
    int          m_drain [3];
    logic [31:0] m_pc    [3];
    logic [2:0]  m_cause [3];
    bit          m_slot  [3];
    int          m_cnt   [3];
    bit          m_cheri [3] = '{1'b1, 1'b0, 1'b1};
    int          m_max   [3] = '{65535, 65535, 3};

    // Oldest valid slot with an event decides; a CJALR error wins over any target.
    task automatic model_pick(input int k, output bit hit, output bit is_exc,
                              output bit s_out, output logic [31:0] t_out,
                              output logic [2:0] c_out);
        logic [31:0] bt_a [2], np_a [2], jt_a [2];
        logic [2:0]  er_a [2];
        bt_a = '{bt0, bt1}; np_a = '{np0, np1}; jt_a = '{jt0, jt1}; er_a = '{e0, e1};
        hit = 0; is_exc = 0; s_out = 0; t_out = 0; c_out = 0;
        for (int s = 0; s < 2; s++) begin
            if (!hit && v[s] && (mt[s] || mnt[s] || jr[s])) begin
                hit = 1;
                s_out = s[0];
                if (m_cheri[k] && jr[s] && er_a[s] != 0) begin
                    is_exc = 1;
                    c_out = er_a[s];
                end else if (mt[s]) t_out = bt_a[s];
                else if (mnt[s]) t_out = np_a[s];
                else t_out = jt_a[s] & ~32'd1;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_rv[k] = 0; m_ev[k] = 0; m_drain[k] = 0; m_pc[k] = 0;
            m_cause[k] = 0; m_slot[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        ready = 1'b0; ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bit          hit, is_exc, s_sel;
        logic [31:0] t_sel;
        logic [2:0]  c_sel;
        bit          idle, ev0;

        vt[0]  = '{2'b01, 2'b00, 2'b01, 2'b00, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h104,  3'd0, 1'b0, 1'b1, 32'h104};
        vt[1]  = '{2'b11, 2'b00, 2'b01, 2'b00, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 32'h104,  3'd0, 1'b0, 1'b1, 32'h104};
        vt[2]  = '{2'b11, 2'b10, 2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h200,  3'd0, 1'b0, 1'b1, 32'h200};
        vt[3]  = '{2'b11, 2'b10, 2'b01, 2'b00, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 32'h104,  3'd0, 1'b0, 1'b1, 32'h104};
        vt[4]  = '{2'b11, 2'b00, 2'b00, 2'b10, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h3000, 3'd0, 1'b0, 1'b1, 32'h3000};
        vt[5]  = '{2'b11, 2'b00, 2'b00, 2'b10, 3'd0, 3'd4, 1'b0, 1'b0, 1'b1, 32'h0,    3'd4, 1'b1, 1'b1, 32'h3000};
        vt[6]  = '{2'b11, 2'b00, 2'b00, 2'b01, 3'd1, 3'd0, 1'b1, 1'b0, 1'b1, 32'h0,    3'd1, 1'b0, 1'b1, 32'h300};
        vt[7]  = '{2'b10, 2'b01, 2'b10, 2'b00, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h204,  3'd0, 1'b0, 1'b1, 32'h204};
        vt[8]  = '{2'b00, 2'b11, 2'b11, 2'b11, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 32'h0,    3'd0, 1'b0, 1'b0, 32'h0};
        vt[9]  = '{2'b11, 2'b00, 2'b00, 2'b01, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 32'h300,  3'd0, 1'b0, 1'b1, 32'h300};
        vt[10] = '{2'b11, 2'b01, 2'b00, 2'b01, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1, 32'h0,    3'd2, 1'b0, 1'b1, 32'h100};
        vt[11] = '{2'b11, 2'b00, 2'b00, 2'b11, 3'd0, 3'd7, 1'b1, 1'b1, 1'b0, 32'h300,  3'd0, 1'b0, 1'b1, 32'h300};
        vt[12] = '{2'b10, 2'b10, 2'b00, 2'b00, 3'd0, 3'd7, 1'b0, 1'b1, 1'b0, 32'h200,  3'd0, 1'b0, 1'b1, 32'h200};

        set_targets();
        do_reset();

        // Reset state for every instance.
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_rv%0d", k), {31'd0, rv[k]}, 32'd0);
            chk($sformatf("reset_ev%0d", k), {31'd0, ev[k]}, 32'd0);
            chk($sformatf("reset_stall%0d", k), {31'd0, stall[k]}, 32'd0);
            chk($sformatf("reset_flush%0d", k), {31'd0, flush[k]}, 32'd0);
            chk($sformatf("reset_cnt%0d", k), {16'd0, cnt[k]}, 32'd0);
            chk($sformatf("reset_pc%0d", k), pc[k], 32'd0);
        end

        // Table vectors: one event, immediate handshake, wait out the drain.
        for (int i = 0; i < 13; i++) begin
            v = vt[i].v; mt = vt[i].mt; mnt = vt[i].mnt; jr = vt[i].jr;
            e0 = vt[i].e0; e1 = vt[i].e1;
            #1;
            chk($sformatf("v%0d_flush", i), {31'd0, flush[0]}, {31'd0, vt[i].fl});
            chk($sformatf("v%0d_stall_evt", i), {31'd0, stall[0]}, 32'd0);
            tick();
            clear_in();
            chk($sformatf("v%0d_rv", i), {31'd0, rv[0]}, {31'd0, vt[i].rv});
            chk($sformatf("v%0d_ev", i), {31'd0, ev[0]}, {31'd0, vt[i].ev});
            chk($sformatf("v%0d_stall", i), {31'd0, stall[0]}, {31'd0, vt[i].rv | vt[i].ev});
            if (vt[i].rv) chk($sformatf("v%0d_pc", i), pc[0], vt[i].pc);
            if (vt[i].ev) begin
                chk($sformatf("v%0d_cause", i), {29'd0, cause[0]}, {29'd0, vt[i].cause});
                chk($sformatf("v%0d_slot", i), {31'd0, slot[0]}, {31'd0, vt[i].slot});
            end
            chk($sformatf("v%0d_nc_rv", i), {31'd0, rv[1]}, {31'd0, vt[i].nrv});
            chk($sformatf("v%0d_nc_ev", i), {31'd0, ev[1]}, 32'd0);
            if (vt[i].nrv) chk($sformatf("v%0d_nc_pc", i), pc[1], vt[i].npc);
            if (vt[i].rv) exp_cnt0++;
            if (vt[i].nrv) exp_cnt1++;
            ready = 1'b1; ack = 1'b1;
            tick();
            ready = 1'b0; ack = 1'b0;
            repeat (DRAIN + 1) tick();
            chk($sformatf("v%0d_idle", i), {31'd0, stall[0]}, 32'd0);
            chk($sformatf("v%0d_cnt", i), {16'd0, cnt[0]}, exp_cnt0);
            chk($sformatf("v%0d_nc_cnt", i), {16'd0, cnt[1]}, exp_cnt1);
        end

        // Held redirect: ready arrives after 3 cycles, pc must not move.
        np0 = 32'h1004;
        v = 2'b11; mnt = 2'b01;
        #1;
        chk("hold_flush", {31'd0, flush[0]}, 32'd1);
        tick();
        clear_in();
        np0 = 32'hdead_beef;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("hold_rv%0d", c), {31'd0, rv[0]}, 32'd1);
            chk($sformatf("hold_pc%0d", c), pc[0], 32'h1004);
            chk($sformatf("hold_stall%0d", c), {31'd0, stall[0]}, 32'd1);
            tick();
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        exp_cnt0++;
        chk("hs_rv", {31'd0, rv[0]}, 32'd0);
        chk("hs_cnt", {16'd0, cnt[0]}, exp_cnt0);
        chk("drain_stall1", {31'd0, stall[0]}, 32'd1);
        tick();
        chk("drain_stall2", {31'd0, stall[0]}, 32'd1);
        tick();
        chk("drain_done", {31'd0, stall[0]}, 32'd0);
        set_targets();

        // Stray ready/ack in IDLE must do nothing.
        ready = 1'b1; ack = 1'b1;
        tick();
        ready = 1'b0; ack = 1'b0;
        chk("stray_rv", {31'd0, rv[0]}, 32'd0);
        chk("stray_stall", {31'd0, stall[0]}, 32'd0);
        chk("stray_cnt", {16'd0, cnt[0]}, exp_cnt0);

        // Held exception: ack late, cause/slot stable, inputs ignored meanwhile.
        v = 2'b10; jr = 2'b10; e1 = 3'b100;
        tick();
        v = 2'b01; mt = 2'b01; jr = 2'b00; e1 = 3'd0;
        repeat (2) begin
            chk("exc_hold_ev", {31'd0, ev[0]}, 32'd1);
            chk("exc_hold_cause", {29'd0, cause[0]}, 32'd4);
            chk("exc_hold_slot", {31'd0, slot[0]}, 32'd1);
            chk("exc_hold_rv", {31'd0, rv[0]}, 32'd0);
            chk("exc_hold_flush", {31'd0, flush[0]}, 32'd0);
            tick();
        end
        clear_in();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("exc_ack_ev", {31'd0, ev[0]}, 32'd0);
        chk("exc_cnt", {16'd0, cnt[0]}, exp_cnt0);
        repeat (DRAIN) tick();

        // Reset while waiting on ready abandons the redirect.
        v = 2'b01; mt = 2'b01;
        tick();
        clear_in();
        tick();
        chk("pre_rst_rv", {31'd0, rv[0]}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_rv", {31'd0, rv[0]}, 32'd0);
        chk("rst_stall", {31'd0, stall[0]}, 32'd0);
        chk("rst_cnt", {16'd0, cnt[0]}, 32'd0);
        rst = 1'b0;

        // Saturation of the 2-bit counter after four accepted redirects.
        for (int r = 0; r < 4; r++) begin
            v = 2'b01; mnt = 2'b01;
            tick();
            clear_in();
            ready = 1'b1;
            tick();
            ready = 1'b0;
            repeat (DRAIN) tick();
        end
        chk("sat_c2", {16'd0, cnt[2]}, 32'd3);
        chk("sat_main", {16'd0, cnt[0]}, 32'd4);

        // Random stimulus against the model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            v = 2'($urandom);
            for (int s = 0; s < 2; s++) begin
                mt[s]  = ($urandom_range(3) == 0);
                mnt[s] = ($urandom_range(3) == 0);
                jr[s]  = ($urandom_range(3) == 0);
                btk[s] = 1'($urandom);
            end
            e0 = ($urandom_range(1) == 1) ? 3'($urandom) : 3'd0;
            e1 = ($urandom_range(1) == 1) ? 3'($urandom) : 3'd0;
            bt0 = $urandom; bt1 = $urandom; np0 = $urandom; np1 = $urandom;
            jt0 = $urandom; jt1 = $urandom;
            ready = 1'($urandom);
            ack = 1'($urandom);
            #1;
            ev0 = v[0] && (mt[0] || mnt[0] || jr[0]);
            for (int k = 0; k < 3; k++) begin
                idle = !(m_rv[k] || m_ev[k] || m_drain[k] > 0);
                chk($sformatf("r%0d_flush%0d", cyc, k), {31'd0, flush[k]}, {31'd0, idle && ev0 && v[1]});
                chk($sformatf("r%0d_stall%0d", cyc, k), {31'd0, stall[k]}, {31'd0, !idle});
                chk($sformatf("r%0d_rv%0d", cyc, k), {31'd0, rv[k]}, {31'd0, m_rv[k]});
                chk($sformatf("r%0d_ev%0d", cyc, k), {31'd0, ev[k]}, {31'd0, m_ev[k]});
                if (m_rv[k]) chk($sformatf("r%0d_pc%0d", cyc, k), pc[k], m_pc[k]);
                if (m_ev[k]) begin
                    chk($sformatf("r%0d_cause%0d", cyc, k), {29'd0, cause[k]}, {29'd0, m_cause[k]});
                    chk($sformatf("r%0d_slot%0d", cyc, k), {31'd0, slot[k]}, {31'd0, m_slot[k]});
                end
                chk($sformatf("r%0d_cnt%0d", cyc, k), {16'd0, cnt[k]}, m_cnt[k]);
            end
            for (int k = 0; k < 3; k++) begin
                if (m_rv[k]) begin
                    if (ready) begin
                        m_rv[k] = 0;
                        m_drain[k] = DRAIN;
                        if (m_cnt[k] < m_max[k]) m_cnt[k]++;
                    end
                end else if (m_ev[k]) begin
                    if (ack) begin
                        m_ev[k] = 0;
                        m_drain[k] = DRAIN;
                    end
                end else if (m_drain[k] > 0) begin
                    m_drain[k]--;
                end else begin
                    model_pick(k, hit, is_exc, s_sel, t_sel, c_sel);
                    if (hit && is_exc) begin
                        m_ev[k] = 1; m_cause[k] = c_sel; m_slot[k] = s_sel;
                    end else if (hit) begin
                        m_rv[k] = 1; m_pc[k] = t_sel;
                    end
                end
            end
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
